// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, ALUctr codes, datapath select encodings and control state
package mips_pkg;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
  } state_t;
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] ext_op;
    logic [1:0] pcsrc;
    logic [3:0] aluctr;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: R-type funct to ALUctr mapping with an unknown-funct flag
module alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluctr,
  output logic       unknown
);
  assign aluctr = funct == F_ADD ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_XOR ? ALU_XOR :
                  funct == F_SLT ? ALU_SLT : ALU_ADD;
  assign unknown = !(funct inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT});
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM driving datapath selects, write enables and ALUctr
module mc_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] ext_op,
  output logic [1:0] pcsrc,
  output logic [3:0] ALUctr,
  output logic       illegal,
  output logic       mem_timeout
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  state_t      state;
  ctrl_t       c;
  logic [CW-1:0] cnt;
  logic [3:0]  r_ctr;
  logic        r_unknown;
  logic        legal;
  logic        waiting;
  alu_dec u_dec (.funct(funct), .aluctr(r_ctr), .unknown(r_unknown));
  assign legal = (opcode == OP_R && !r_unknown) ||
                 opcode inside {OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
  assign waiting = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // per-state control decode; everything forced low while reset is held
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_re  = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.ir_we   = mem_ready;
        c.pc_we   = mem_ready;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMM4;
        c.ext_op  = EXT_SIGN;
        c.illegal = !legal;
      end
      S_EXEC_R: begin
        c.alusrca = SRCA_RS;
        c.aluctr  = r_ctr;
      end
      S_EXEC_I: begin
        c.alusrca = opcode == OP_LUI ? SRCA_ZERO : SRCA_RS;
        c.alusrcb = SRCB_IMM;
        c.ext_op  = opcode == OP_ORI ? EXT_ZERO : opcode == OP_LUI ? EXT_HI : EXT_SIGN;
        c.aluctr  = opcode == OP_ORI ? ALU_OR : opcode == OP_LUI ? ALU_LUI : ALU_ADD;
      end
      S_ALU_WB: begin
        c.reg_we = 1'b1;
        c.regdst = opcode == OP_R;
      end
      S_MEM_ADDR: begin
        c.alusrca = SRCA_RS;
        c.alusrcb = SRCB_IMM;
        c.ext_op  = EXT_SIGN;
      end
      S_MEM_RD: begin
        c.mem_re = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_we   = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_we = 1'b1;
        c.iord   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = SRCA_RS;
        c.aluctr  = ALU_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.pc_we   = zero;
      end
      S_JUMP: begin
        c.pcsrc = PC_JUMP;
        c.pc_we = 1'b1;
      end
      default: c = '0;
    endcase
    if (rst) c = '0;
  end
  assign {pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, memtoreg,
          alusrca, alusrcb, ext_op, pcsrc, ALUctr, illegal} = c;
  // state sequencing plus the memory-wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= !legal ? S_FETCH :
                             opcode == OP_R ? S_EXEC_R :
                             opcode inside {OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI} ? S_EXEC_I :
                             opcode inside {OP_LW, OP_SW} ? S_MEM_ADDR :
                             opcode == OP_BEQ ? S_BRANCH : S_JUMP;
        S_EXEC_R:   state <= S_ALU_WB;
        S_EXEC_I:   state <= S_ALU_WB;
        S_MEM_ADDR: state <= opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        default:    state <= S_FETCH;
      endcase
      if (waiting && !mem_ready) begin
        if (cnt != CW'(MEM_WAIT_MAX)) cnt <= cnt + 1'b1;
        if (cnt >= CW'(MEM_WAIT_MAX - 1)) mem_timeout <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed-step checks of the multicycle control sequencing
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic [5:0] funct = 6'b100000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, memtoreg, illegal, mem_timeout;
  logic [1:0] alusrca, alusrcb, ext_op, pcsrc;
  logic [3:0] ALUctr;
  logic [20:0] obs;
  int checks = 0;
  int failures = 0;
  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we),
    .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .ext_op(ext_op), .pcsrc(pcsrc), .ALUctr(ALUctr),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );
  assign obs = {pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, memtoreg,
                alusrca, alusrcb, ext_op, pcsrc, ALUctr, illegal};
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic exp_o(input string tag, input logic pw, input logic iw, input logic io,
                       input logic mr, input logic mw, input logic rw, input logic rd,
                       input logic mtr, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] x, input logic [1:0] p, input logic [3:0] u,
                       input logic il);
    #1;
    chk(tag, 32'(obs), 32'({pw, iw, io, mr, mw, rw, rd, mtr, a, b, x, p, u, il}));
  endtask
  initial begin
    #2;
    exp_o("reset_outputs", 0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    chk("reset_timeout", 32'(mem_timeout), 0);
    cyc();
    rst = 1'b0;
    exp_o("add_fetch",  1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("add_decode", 0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,4'b0000,0);
    cyc();
    exp_o("add_exec",   0,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("add_wb",     0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    funct = 6'b101010;
    exp_o("slt_fetch",  1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    cyc(); cyc();
    exp_o("slt_exec",   0,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,4'b0110,0);
    cyc(); cyc();
    opcode = 6'b100011;
    cyc();
    exp_o("lw_decode",  0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,4'b0000,0);
    cyc();
    exp_o("lw_addr",    0,0,0,0,0,0,0,0, 2'b01,2'b10,2'b01,2'b00,4'b0000,0);
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      exp_o("lw_rd_wait", 0,0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
      cyc();
    end
    mem_ready = 1'b1;
    exp_o("lw_rd_done", 0,0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("lw_wb",      0,0,0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("lw_next_fetch", 1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    opcode = 6'b101011;
    cyc(); cyc(); cyc();
    exp_o("sw_wr",      0,0,1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    opcode = 6'b000100;
    zero = 1'b1;
    cyc(); cyc();
    exp_o("beq_taken",  1,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b01,4'b0001,0);
    zero = 1'b0;
    exp_o("beq_not",    0,0,0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b01,4'b0001,0);
    cyc();
    opcode = 6'b001111;
    exp_o("beq_to_fetch", 1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    cyc(); cyc();
    exp_o("lui_exec",   0,0,0,0,0,0,0,0, 2'b10,2'b10,2'b10,2'b00,4'b0101,0);
    cyc();
    exp_o("lui_wb",     0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    cyc();
    opcode = 6'b001101;
    cyc(); cyc();
    #1;
    chk("ori_ext", 32'(ext_op), 0);
    chk("ori_alu", 32'(ALUctr), 3);
    chk("ori_srcb", 32'(alusrcb), 2);
    cyc(); cyc();
    opcode = 6'b000010;
    cyc(); cyc();
    exp_o("j_jump",     1,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10,4'b0000,0);
    cyc();
    opcode = 6'b111111;
    cyc();
    exp_o("ill_op_decode", 0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,4'b0000,1);
    cyc();
    opcode = 6'b000000;
    funct = 6'b000111;
    exp_o("ill_op_fetch", 1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("ill_fn_decode", 0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,4'b0000,1);
    cyc();
    funct = 6'b100000;
    mem_ready = 1'b0;
    exp_o("ill_fn_fetch", 0,0,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk($sformatf("timeout_%0d", i), 32'(mem_timeout), 32'(i >= 15));
    end
    exp_o("timeout_fetch_hold", 0,0,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    rst = 1'b1;
    exp_o("rst_mid_outputs", 0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,4'b0000,0);
    chk("rst_mid_timeout", 32'(mem_timeout), 0);
    cyc();
    rst = 1'b0;
    mem_ready = 1'b1;
    exp_o("rst_restart_fetch", 1,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,4'b0000,0);
    cyc();
    exp_o("rst_restart_decode", 0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b01,2'b00,4'b0000,0);
    chk("rst_timeout_low", 32'(mem_timeout), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the MIPS core. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath mux selects, write enables and the 4-bit `ALUctr` code consumed by the ALU. Sits directly upstream of the ALU: opcode/funct come from the instruction register; the ALU `zero` flag returns for branch resolution.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: cycles a memory state may wait for `mem_ready` before `mem_timeout` is flagged.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26], stable from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the access this cycle
- `pc_we`  out  1  PC write
- `ir_we`  out  1  IR load
- `iord`  out  1  memory address: 0=PC, 1=ALUOut
- `mem_re` / `mem_we`  out  1 each  memory read / write request
- `reg_we`  out  1  register file write
- `regdst`  out  1  0=rt, 1=rd
- `memtoreg`  out  1  0=ALUOut, 1=MDR
- `alusrca`  out  2  00=PC, 01=rs, 10=zero
- `alusrcb`  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- `ext_op`  out  2  00=zero-ext, 01=sign-ext, 10=imm<<16
- `pcsrc`  out  2  00=ALU result, 01=ALUOut, 10=jump target
- `ALUctr`  out  4  ALU operation
- `illegal`  out  1  one-cycle pulse on an unsupported opcode/funct
- `mem_timeout`  out  1  sticky, cleared only by reset

## Operation
- ALUctr codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 lui (A+B with A=0, B=imm<<16), 0110 slt. No other codes are emitted.
- Supported opcodes: R=000000 (funct add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010), addi 001000, addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- States and transitions:
  - FETCH: `mem_re`, `iord`=0, alusrca=00, alusrcb=01, add, pcsrc=00. On `mem_ready`: `ir_we`=1, `pc_we`=1, go to DECODE; otherwise hold.
  - DECODE: compute PC+(sext imm<<2) into ALUOut (alusrca=00, alusrcb=11, ext_op=01, add). Dispatch: R→EXEC_R; addi/addiu/ori/lui→EXEC_I; lw/sw→MEM_ADDR; beq→BRANCH; j→JUMP; anything else→FETCH with `illegal`=1. An R-type with unknown funct also takes this path.
  - EXEC_R: alusrca=01, alusrcb=00, ALUctr from funct → ALU_WB.
  - EXEC_I: alusrcb=10; addi/addiu: ext_op=01, add; ori: ext_op=00, or; lui: alusrca=10, ext_op=10, lui → ALU_WB.
  - ALU_WB: `reg_we`=1, memtoreg=0, regdst=1 for R-type else 0 → FETCH.
  - MEM_ADDR: alusrca=01, alusrcb=10, ext_op=01, add → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: `mem_re`, `iord`=1; on `mem_ready` → MEM_WB. MEM_WB: `reg_we`, memtoreg=1, regdst=0 → FETCH.
  - MEM_WR: `mem_we`, `iord`=1; on `mem_ready` → FETCH.
  - BRANCH: alusrca=01, alusrcb=00, sub, pcsrc=01, `pc_we`=`zero` → FETCH.
  - JUMP: pcsrc=10, `pc_we`=1 → FETCH.
- Outputs not listed for a state are 0.
- Wait counter: counts consecutive non-ready cycles in FETCH/MEM_RD/MEM_WR. On reaching `MEM_WAIT_MAX`, set `mem_timeout`; the state keeps waiting. The counter clears on any state change.

## Timing
- State register updates on the rising edge of `clk`. Outputs are combinational from the state plus opcode/funct/`zero`; there is no output register.
- Reset: state=FETCH, wait counter=0, `mem_timeout`=0. While `rst` is high, every output is 0, including the FETCH strobes. A reset mid-instruction abandons it and returns to FETCH the next cycle after release.
- Cycle counts with `mem_ready` always 1: R/ALU-imm 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each memory-wait cycle adds one.
- `illegal` is asserted only in the DECODE cycle.

## Structure
- Shared package `mips_pkg`: opcode and funct constants, ALUctr codes, alusrca/alusrcb/ext_op/pcsrc encodings, state enum. The ALU uses the same ALUctr constants.
- One sub-module `alu_dec`: combinational funct→ALUctr mapping with an `unknown` flag, used in EXEC_R and in the DECODE legality check.

## Test plan
- `add` (funct 100000), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB; ALUctr=0000 in EXEC_R; `reg_we`=1 and regdst=1 in cycle 4 only.
- `lw`, `mem_ready` low for 3 cycles in MEM_RD → 8 total cycles; `mem_re`=1, `iord`=1 throughout MEM_RD; `reg_we`=1 with memtoreg=1 in MEM_WB.
- `beq` with zero=1 then zero=0 → BRANCH `pc_we` = 1 then 0; pcsrc=01; ALUctr=0001.
- `lui` → EXEC_I drives alusrca=10, ext_op=10, ALUctr=0101; `ori` → ext_op=00, ALUctr=0011.
- opcode 111111, and R-type with funct 000111 → `illegal` one-cycle pulse in DECODE, no write enables, back in FETCH at cycle 3.
- `mem_ready` held 0 in FETCH for 20 cycles → `mem_timeout` rises after 15 and stays high; `rst` pulse mid-wait → all outputs 0, `mem_timeout` cleared, FETCH restarts.
